// File: rtl/fullconn_backprop_l3.sv
// Layer-3 backward pass: gated error, mux-scaled back error to layer 2, and a windowed
// per-weight gradient accumulator that streams its 40 counts out over valid/ready.

module fullconn_backprop_l3_cnt #(
   parameter int CNTW = 8
) (
   input  logic            CLK,
   input  logic            INIT,
   input  logic            clr,
   input  logic            en,
   input  logic            dec,
   output logic [CNTW-1:0] nxt
);
   localparam logic [CNTW-1:0] MAXV = {1'b0, {(CNTW-1){1'b1}}};
   localparam logic [CNTW-1:0] MINV = {1'b1, {(CNTW-1){1'b0}}};

   logic [CNTW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                          cnt_d = '0;
      else if (en && !dec && cnt_q != MAXV) cnt_d = cnt_q + CNTW'(1);
      else if (en &&  dec && cnt_q != MINV) cnt_d = cnt_q - CNTW'(1);
   end

   always_ff @(posedge CLK or negedge INIT) begin
      if (!INIT) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Next value is exported so the first dump word already sees the final accumulation.
   assign nxt = cnt_d;
endmodule

module fullconn_backprop_l3 #(
   parameter int WINDOW = 256,
   parameter int CNTW   = 8
) (
   input  logic            CLK,
   input  logic            INIT,
   input  logic            CLK_TRAINING_flag,
   input  logic [4:0]      delta,
   input  logic [4:0]      SIGN_delta,
   input  logic [4:0]      zp,
   input  logic [7:0]      a_input,
   input  logic [7:0]      alpha_j_0,
   input  logic [7:0]      alpha_j_1,
   input  logic [7:0]      alpha_j_2,
   input  logic [7:0]      alpha_j_3,
   input  logic [7:0]      alpha_j_4,
   input  logic [7:0]      SIGN_alpha_j_0,
   input  logic [7:0]      SIGN_alpha_j_1,
   input  logic [7:0]      SIGN_alpha_j_2,
   input  logic [7:0]      SIGN_alpha_j_3,
   input  logic [7:0]      SIGN_alpha_j_4,
   output logic [7:0]      delta_prev,
   output logic [7:0]      SIGN_delta_prev,
   output logic [CNTW-1:0] grad_data,
   output logic [5:0]      grad_idx,
   output logic            grad_valid,
   input  logic            grad_ready,
   output logic            busy
);
   localparam int NJ = 5;
   localparam int NI = 8;
   localparam int NW = NJ * NI;
   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
   localparam logic [5:0]    IDX_LAST = 6'(NW - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

   logic [NJ-1:0][NI-1:0]   alpha, salpha;
   logic [NJ-1:0]           e;
   logic [NW-1:0][CNTW-1:0] cnt_nxt;

   assign alpha  = {alpha_j_4, alpha_j_3, alpha_j_2, alpha_j_1, alpha_j_0};
   assign salpha = {SIGN_alpha_j_4, SIGN_alpha_j_3, SIGN_alpha_j_2, SIGN_alpha_j_1, SIGN_alpha_j_0};
   assign e      = delta & zp;

   // Back-error path: one node per cycle, so the stream is the 1/5-scaled sum over nodes.
   logic [2:0] jsel_d, jsel_q;
   logic [7:0] dp_d, dp_q, sdp_d, sdp_q;

   always_comb begin
      jsel_d = (jsel_q == 3'd4) ? 3'd0 : jsel_q + 3'd1;
      dp_d   = e[jsel_q] ? alpha[jsel_q] : 8'h00;
      sdp_d  = dp_d & (salpha[jsel_q] ^ {NI{SIGN_delta[jsel_q]}});
   end

   // Gradient FSM
   state_t          state_d, state_q;
   logic [WW-1:0]   win_d, win_q;
   logic [5:0]      idx_d, idx_q;
   logic            clr_all, acc_en;
   logic            gv_d, gv_q, busy_d, busy_q;
   logic [5:0]      gi_d, gi_q;
   logic [CNTW-1:0] gd_d, gd_q;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      idx_d   = idx_q;
      clr_all = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         IDLE: if (CLK_TRAINING_flag) begin
            clr_all = 1'b1;
            win_d   = '0;
            state_d = ACCUM;
         end
         ACCUM: if (!CLK_TRAINING_flag) begin
            state_d = IDLE;
         end else begin
            acc_en = 1'b1;
            win_d  = win_q + WW'(1);
            if (win_q == WIN_LAST) begin
               state_d = DUMP;
               idx_d   = '0;
            end
         end
         DUMP: if (gv_q && grad_ready) begin
            if (idx_q == IDX_LAST) state_d = IDLE;
            else                   idx_d   = idx_q + 6'd1;
         end
         default: state_d = IDLE;
      endcase
      gv_d   = (state_d == DUMP);
      gi_d   = gv_d ? idx_d : 6'd0;
      gd_d   = gv_d ? cnt_nxt[idx_d] : '0;
      busy_d = (state_d != IDLE);
   end

   for (genvar j = 0; j < NJ; j++) begin : g_node
      for (genvar i = 0; i < NI; i++) begin : g_in
         fullconn_backprop_l3_cnt #(.CNTW(CNTW)) u_cnt (
            .CLK  (CLK),
            .INIT (INIT),
            .clr  (clr_all),
            .en   (acc_en & e[j] & a_input[i]),
            .dec  (SIGN_delta[j]),
            .nxt  (cnt_nxt[j*NI+i])
         );
      end
   end

   always_ff @(posedge CLK or negedge INIT) begin
      if (!INIT) begin
         state_q <= IDLE;
         win_q   <= '0;
         idx_q   <= '0;
         jsel_q  <= '0;
         dp_q    <= '0;
         sdp_q   <= '0;
         gv_q    <= 1'b0;
         gi_q    <= '0;
         gd_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         idx_q   <= idx_d;
         jsel_q  <= jsel_d;
         dp_q    <= dp_d;
         sdp_q   <= sdp_d;
         gv_q    <= gv_d;
         gi_q    <= gi_d;
         gd_q    <= gd_d;
         busy_q  <= busy_d;
      end
   end

   assign delta_prev      = dp_q;
   assign SIGN_delta_prev = sdp_q;
   assign grad_valid      = gv_q;
   assign grad_idx        = gi_q;
   assign grad_data       = gd_q;
   assign busy            = busy_q;
endmodule

// File: tb/tb_fullconn_backprop_l3.sv
// Bench for fullconn_backprop_l3: a WINDOW=16 instance for most scenarios and a WINDOW=300
// instance for saturation; expected dump words and back-error samples go through queues.
module tb_fullconn_backprop_l3;
   typedef struct packed {logic [5:0] idx; logic [7:0] data;} word_t;

   logic       CLK = 1'b0;
   logic       INIT = 1'b0;
   logic       flag16 = 1'b0, flag300 = 1'b0, ready16 = 1'b0, ready300 = 1'b0;
   logic [4:0] delta = '0, sdelta = '0, zp = '0;
   logic [7:0] a_input = '0;
   logic [7:0] alpha [5];
   logic [7:0] salpha [5];

   logic [7:0] dp16, sdp16, gd16, dp300, sdp300, gd300;
   logic [5:0] gi16, gi300;
   logic       gv16, busy16, gv300, busy300;

   int n_chk = 0, n_fail = 0;
   int jsel_m = 0;
   int cnt_m [40];
   word_t exp_q [$];
   logic [15:0] be_q [$];

   always #5 CLK = ~CLK;

   fullconn_backprop_l3 #(.WINDOW(16), .CNTW(8)) u_dut (
      .CLK(CLK), .INIT(INIT), .CLK_TRAINING_flag(flag16), .delta(delta), .SIGN_delta(sdelta),
      .zp(zp), .a_input(a_input),
      .alpha_j_0(alpha[0]), .alpha_j_1(alpha[1]), .alpha_j_2(alpha[2]), .alpha_j_3(alpha[3]),
      .alpha_j_4(alpha[4]),
      .SIGN_alpha_j_0(salpha[0]), .SIGN_alpha_j_1(salpha[1]), .SIGN_alpha_j_2(salpha[2]),
      .SIGN_alpha_j_3(salpha[3]), .SIGN_alpha_j_4(salpha[4]),
      .delta_prev(dp16), .SIGN_delta_prev(sdp16), .grad_data(gd16), .grad_idx(gi16),
      .grad_valid(gv16), .grad_ready(ready16), .busy(busy16));

   fullconn_backprop_l3 #(.WINDOW(300), .CNTW(8)) u_sat (
      .CLK(CLK), .INIT(INIT), .CLK_TRAINING_flag(flag300), .delta(delta), .SIGN_delta(sdelta),
      .zp(zp), .a_input(a_input),
      .alpha_j_0(alpha[0]), .alpha_j_1(alpha[1]), .alpha_j_2(alpha[2]), .alpha_j_3(alpha[3]),
      .alpha_j_4(alpha[4]),
      .SIGN_alpha_j_0(salpha[0]), .SIGN_alpha_j_1(salpha[1]), .SIGN_alpha_j_2(salpha[2]),
      .SIGN_alpha_j_3(salpha[3]), .SIGN_alpha_j_4(salpha[4]),
      .delta_prev(dp300), .SIGN_delta_prev(sdp300), .grad_data(gd300), .grad_idx(gi300),
      .grad_valid(gv300), .grad_ready(ready300), .busy(busy300));

   task automatic tick;
      @(posedge CLK);
      if (INIT) jsel_m = (jsel_m == 4) ? 0 : jsel_m + 1;
      #1;
   endtask

   function automatic logic [15:0] be_model();
      logic [7:0] dp, sdp;
      int j = jsel_m;
      dp  = (delta[j] & zp[j]) ? alpha[j] : 8'h00;
      sdp = dp & (salpha[j] ^ {8{sdelta[j]}});
      return {dp, sdp};
   endfunction

   task automatic model_acc;
      for (int j = 0; j < 5; j++)
         for (int i = 0; i < 8; i++)
            if (delta[j] & zp[j] & a_input[i]) begin
               if (sdelta[j]) begin if (cnt_m[j*8+i] > -128) cnt_m[j*8+i]--; end
               else           begin if (cnt_m[j*8+i] <  127) cnt_m[j*8+i]++; end
            end
   endtask

   task automatic push_dump;
      word_t w;
      for (int k = 0; k < 40; k++) begin
         w.idx = 6'(k); w.data = 8'(cnt_m[k]);
         exp_q.push_back(w);
      end
   endtask

   task automatic clear_model;
      for (int k = 0; k < 40; k++) cnt_m[k] = 0;
   endtask

   task automatic rand_inputs;
      delta = 5'($urandom); zp = 5'($urandom); sdelta = 5'($urandom); a_input = 8'($urandom);
   endtask

   // Drain nhs dump words from one instance; bp selects the 1,0,0 ready pattern.
   task automatic collect(input bit sel, input bit bp, input int nhs, input int budget);
      int hs = 0, cyc = 0;
      logic rdy, v;
      logic [5:0] gi;
      logic [7:0] gd;
      word_t w;
      while (hs < nhs && cyc < budget) begin
         rdy = bp ? (cyc % 3 == 0) : 1'b1;
         if (sel) ready300 = rdy; else ready16 = rdy;
         v  = sel ? gv300 : gv16;
         gi = sel ? gi300 : gi16;
         gd = sel ? gd300 : gd16;
         if (v) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL dump_extra: got idx %0d data %0d, no word expected", gi, gd);
            end else begin
               w = exp_q[0];
               if (gi !== w.idx || gd !== w.data) begin
                  n_fail++;
                  $display("FAIL dump_word (ready=%0b): got idx %0d data %0d, want idx %0d data %0d",
                           rdy, gi, $signed(gd), w.idx, $signed(w.data));
               end
               if (rdy) begin void'(exp_q.pop_front()); hs++; end
            end
         end
         tick;
         cyc++;
      end
      n_chk++;
      if (hs != nhs) begin
         n_fail++;
         $display("FAIL dump_count: got %0d handshakes, want %0d", hs, nhs);
      end
   endtask

   task automatic check_idle_after_dump(input bit sel);
      n_chk++;
      if ((sel ? gv300 : gv16) !== 1'b0 || (sel ? busy300 : busy16) !== 1'b0) begin
         n_fail++;
         $display("FAIL dump_end: got valid %0b busy %0b, want 0 0",
                  sel ? gv300 : gv16, sel ? busy300 : busy16);
      end
   endtask

   task automatic test_reset;
      INIT = 1'b0; jsel_m = 0; flag16 = 1'b1; flag300 = 1'b1; ready16 = 1'b1; ready300 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         rand_inputs();
         for (int j = 0; j < 5; j++) begin alpha[j] = 8'($urandom); salpha[j] = 8'($urandom); end
         tick;
         n_chk++;
         if ({dp16, sdp16, gd16, gi16, gv16, busy16, dp300, sdp300, gd300, gi300, gv300, busy300} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dp %h sdp %h gd %h gi %h gv %b busy %b, want all 0",
                     dp16, sdp16, gd16, gi16, gv16, busy16);
         end
      end
      flag16 = 1'b0; flag300 = 1'b0; delta = '0;
      INIT = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick;
         n_chk++;
         if (dp16 !== 8'h00 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got dp %h busy %b, want 00 0", dp16, busy16);
         end
      end
   endtask

   task automatic test_back_error;
      logic [15:0] e;
      delta = 5'b00001; zp = 5'b00001; sdelta = '0;
      for (int j = 0; j < 5; j++) begin alpha[j] = 8'h00; salpha[j] = 8'h00; end
      alpha[0] = 8'hFF; salpha[0] = 8'h0F;
      for (int c = 0; c < 15; c++) begin
         // Independent of the generic model: only jsel=0 cycles carry the FF/0F pattern.
         be_q.push_back((jsel_m == 0) ? 16'hFF0F : 16'h0000);
         tick;
         e = be_q.pop_front();
         n_chk++;
         if ({dp16, sdp16} !== e) begin
            n_fail++;
            $display("FAIL back_error c%0d: got dp %h sdp %h, want %h %h", c, dp16, sdp16, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_back_error_random;
      logic [15:0] e;
      for (int c = 0; c < 40; c++) begin
         rand_inputs();
         for (int j = 0; j < 5; j++) begin alpha[j] = 8'($urandom); salpha[j] = 8'($urandom); end
         be_q.push_back(be_model());
         tick;
         e = be_q.pop_front();
         n_chk++;
         if ({dp16, sdp16} !== e) begin
            n_fail++;
            $display("FAIL back_error_rand c%0d: got dp %h sdp %h, want %h %h", c, dp16, sdp16, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_accumulate;
      delta = 5'b00100; zp = 5'b00100; sdelta = 5'b00100; a_input = 8'h01;
      clear_model();
      flag16 = 1'b1; ready16 = 1'b1;
      tick;
      for (int c = 0; c < 16; c++) begin
         n_chk++;
         if (busy16 !== 1'b1 || gv16 !== 1'b0) begin
            n_fail++;
            $display("FAIL accum_busy c%0d: got busy %b valid %b, want 1 0", c, busy16, gv16);
         end
         model_acc();
         tick;
      end
      push_dump();
      n_chk++;
      if (exp_q[16].data !== 8'hF0) begin
         n_fail++;
         $display("FAIL accum_model: got idx16 %h, want f0", exp_q[16].data);
      end
      collect(1'b0, 1'b0, 40, 100);
      check_idle_after_dump(1'b0);
      tick;
      n_chk++;
      if (busy16 !== 1'b1) begin
         n_fail++;
         $display("FAIL reentry: got busy %b, want 1", busy16);
      end
      flag16 = 1'b0;
      tick;
      n_chk++;
      if (busy16 !== 1'b0) begin
         n_fail++;
         $display("FAIL reentry_abort: got busy %b, want 0", busy16);
      end
   endtask

   task automatic test_backpressure;
      flag16 = 1'b1;
      tick;
      clear_model();
      for (int c = 0; c < 16; c++) begin
         rand_inputs();
         model_acc();
         tick;
      end
      flag16 = 1'b0;
      push_dump();
      collect(1'b0, 1'b1, 40, 400);
      check_idle_after_dump(1'b0);
   endtask

   task automatic test_saturation;
      delta = 5'b00001; zp = 5'b00001; sdelta = '0; a_input = 8'hFF;
      clear_model();
      flag300 = 1'b1; ready300 = 1'b1;
      tick;
      for (int c = 0; c < 300; c++) begin
         model_acc();
         tick;
      end
      flag300 = 1'b0;
      push_dump();
      n_chk++;
      if (exp_q[0].data !== 8'd127 || exp_q[8].data !== 8'd0) begin
         n_fail++;
         $display("FAIL sat_model: got %0d %0d, want 127 0", exp_q[0].data, exp_q[8].data);
      end
      collect(1'b1, 1'b0, 40, 100);
      check_idle_after_dump(1'b1);
   endtask

   task automatic test_abort_reset;
      flag16 = 1'b1;
      tick;
      for (int c = 0; c < 5; c++) begin rand_inputs(); tick; end
      flag16 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick;
         n_chk++;
         if (gv16 !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort c%0d: got valid %b busy %b, want 0 0", c, gv16, busy16);
         end
      end
      flag16 = 1'b1;
      tick;
      clear_model();
      for (int c = 0; c < 16; c++) begin rand_inputs(); model_acc(); tick; end
      flag16 = 1'b0;
      push_dump();
      collect(1'b0, 1'b0, 12, 100);
      n_chk++;
      if (gv16 !== 1'b1 || gi16 !== 6'd12) begin
         n_fail++;
         $display("FAIL pre_reset: got valid %b idx %0d, want 1 12", gv16, gi16);
      end
      INIT = 1'b0; jsel_m = 0;
      #1;
      n_chk++;
      if (gv16 !== 1'b0 || gi16 !== 6'd0 || gd16 !== 8'd0 || busy16 !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_dump_reset: got valid %b idx %0d data %h busy %b, want 0 0 00 0",
                  gv16, gi16, gd16, busy16);
      end
      exp_q.delete();
      tick;
      INIT = 1'b1;
      delta = 5'b10000; zp = 5'b10000; sdelta = '0; a_input = 8'h80;
      flag16 = 1'b1;
      tick;
      clear_model();
      for (int c = 0; c < 16; c++) begin model_acc(); tick; end
      flag16 = 1'b0;
      push_dump();
      collect(1'b0, 1'b0, 40, 100);
      check_idle_after_dump(1'b0);
   endtask

   initial begin
      for (int j = 0; j < 5; j++) begin alpha[j] = '0; salpha[j] = '0; end
      test_reset();
      test_back_error();
      test_back_error_random();
      test_accumulate();
      test_backpressure();
      test_saturation();
      test_abort_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
